// File: rtl/serialize_ctrl_pkg.sv
// rtl/serialize_ctrl_pkg.sv - state enum and counter-width helper for serialize_ctrl (option SERIALIZE_CTRL_PARITY_EN)
package serialize_ctrl_pkg;

`ifdef SERIALIZE_CTRL_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  // Counter must hold 0..WIDTH-1 plus headroom so it never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serialize_ctrl_if.sv
// rtl/serialize_ctrl_if.sv - parallel-in / serial-out handshake bundle for serialize_ctrl
interface serialize_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             ser_valid;
  logic             ser_out;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, ser_valid, ser_out, frame_start, frame_end, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, ser_valid, ser_out, frame_start, frame_end, busy
  );
endinterface

// File: rtl/serialize_shreg.sv
// rtl/serialize_shreg.sv - WIDTH-bit parallel-load shift register presenting its MSB
module serialize_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] q;

  // Load wins over shift; shifting left moves the next bit into the MSB slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[WIDTH-1];
endmodule

// File: rtl/serialize_ctrl.sv
// rtl/serialize_ctrl.sv - word serializer FSM, MSB first, optional even parity bit (SERIALIZE_CTRL_PARITY_EN)
module serialize_ctrl
  import serialize_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  serialize_ctrl_if.slave bus
);
  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             load;
  logic             shift;
  logic             sh_msb;

  assign last_bit = (cnt == LAST);

  serialize_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (bus.in_data),
    .msb  (sh_msb)
  );

`ifdef SERIALIZE_CTRL_PARITY_EN
  logic parity_q;

  // Even parity of the captured word, frozen at load time since the shifter destroys the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^bus.in_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: load from IDLE, leave SHIFT only when the last data bit is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid && !rst) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.out_ready && last_bit) begin
`ifdef SERIALIZE_CTRL_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef SERIALIZE_CTRL_PARITY_EN
      ST_PARITY: begin
        if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from the current state.
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.ser_valid   = 1'b0;
    bus.ser_out     = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.busy        = 1'b0;
    load            = 1'b0;
    shift           = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = !rst;
        load         = bus.in_valid && !rst;
      end
      ST_SHIFT: begin
        bus.ser_valid   = 1'b1;
        bus.busy        = 1'b1;
        bus.ser_out     = sh_msb;
        bus.frame_start = (cnt == '0);
`ifndef SERIALIZE_CTRL_PARITY_EN
        bus.frame_end   = last_bit;
`endif
        shift           = bus.out_ready;
      end
`ifdef SERIALIZE_CTRL_PARITY_EN
      ST_PARITY: begin
        bus.ser_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.ser_out   = parity_q;
        bus.frame_end = 1'b1;
      end
`endif
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

  // Bit counter: cleared on load, advances per accepted data bit, parks on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (state == ST_SHIFT && bus.out_ready && !last_bit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_serialize_ctrl.sv
// tb/tb_serialize_ctrl.sv - scoreboard bench for serialize_ctrl (WIDTH=4 random + WIDTH=1 directed)
module tb_serialize_ctrl;
  localparam int W = 4;
`ifdef SERIALIZE_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serialize_ctrl_if #(.WIDTH(W)) bus ();
  serialize_ctrl_if #(.WIDTH(1)) bus1 ();

  serialize_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  serialize_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic b;
    logic s;
    logic e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is the word's bits MSB first, optionally followed by its even parity bit.
  task automatic push_word(input logic [W-1:0] d);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.b = d[i];
      e.s = (i == W - 1);
      e.e = (i == 0) && !PAR;
      q.push_back(e);
    end
    if (PAR) begin
      e.b = (($countones(d) % 2) == 1);
      e.s = 1'b0;
      e.e = 1'b1;
      q.push_back(e);
    end
  endtask

  // Monitor: idle exactly when nothing is owed; compare every presented bit, pop on acceptance.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_ser_valid", bus.ser_valid, 0);
      chk("rst_ser_out", bus.ser_out, 0);
      chk("rst_frame_start", bus.frame_start, 0);
      chk("rst_frame_end", bus.frame_end, 0);
      chk("rst_busy", bus.busy, 0);
      q.delete();
    end else begin
      chk("in_ready", bus.in_ready, 32'(q.size() == 0));
      chk("busy", bus.busy, 32'(q.size() != 0));
      chk("ser_valid", bus.ser_valid, 32'(q.size() != 0));
      if (bus.ser_valid && q.size() > 0) begin
        chk("ser_out", bus.ser_out, q[0].b);
        chk("frame_start", bus.frame_start, q[0].s);
        chk("frame_end", bus.frame_end, q[0].e);
        if (bus.out_ready) void'(q.pop_front());
      end else if (!bus.ser_valid) begin
        chk("idle_ser_out", bus.ser_out, 0);
        chk("idle_frame_start", bus.frame_start, 0);
        chk("idle_frame_end", bus.frame_end, 0);
      end
      if (bus.in_valid && bus.in_ready) push_word(bus.in_data);
    end
  end

  // Present a word, then apply out_ready from pat (bit i = cycle i after load); optional reset at cycle rst_at.
  task automatic send(input logic [W-1:0] d, input logic [15:0] pat, input int rst_at);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("handshake_timeout", 32'(got), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    for (int i = 0; i < 16; i++) begin
      if (i == rst_at) rst = 1'b1;
      bus.out_ready = pat[i];
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    bus.out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send(4'b1011, 16'hFFFF, -1);
    send(4'b1011, 16'b1111_1111_1111_1001, -1);
    send(4'b0111, 16'hFFFF, -1);
    send(4'b1100, 16'hFFFF, 2);
    send(4'b0001, 16'hFFFF, -1);
    send(4'b1111, 16'b1010_1010_1010_1010, -1);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_data   = W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 99) == 0);
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);

    bus1.in_valid  = 1'b1;
    bus1.in_data   = 1'b1;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    chk("w1_in_ready", bus1.in_ready, 1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 1'b0;
    @(negedge clk);
    chk("w1_ser_valid", bus1.ser_valid, 1);
    chk("w1_ser_out", bus1.ser_out, 1);
    chk("w1_frame_start", bus1.frame_start, 1);
    chk("w1_frame_end", bus1.frame_end, 32'(!PAR));
    chk("w1_busy_ready", bus1.in_ready, 0);
    if (PAR) begin
      @(negedge clk);
      chk("w1_par_out", bus1.ser_out, 1);
      chk("w1_par_start", bus1.frame_start, 0);
      chk("w1_par_end", bus1.frame_end, 1);
    end
    @(negedge clk);
    chk("w1_ready_back", bus1.in_ready, 1);
    chk("w1_idle_valid", bus1.ser_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
